// File: rtl/row_hit_arbiter_if.sv
// Shared types and the bus interface for the row-hit request arbiter.
// The package carries the packet/command encodings used by both the
// arbiter and whoever drives it; the interface bundles every non-clock
// signal of the arbiter into master (requester side) and slave (arbiter).

package row_hit_arbiter_pkg;

  localparam int BK_ADDR_WIDTH  = 3;
  localparam int ROW_ADDR_WIDTH = 12;
  localparam int COL_ADDR_WIDTH = 10;
  localparam int TAG_WIDTH      = 6;
  localparam int NUM_BANKS      = 1 << BK_ADDR_WIDTH;

  // Commands broadcast by the bank arbiter; only ACT/PREPB/PREAB touch
  // the open-row table, the rest are observed and ignored.
  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_ACT   = 3'd1,
    CMD_RD    = 3'd2,
    CMD_WR    = 3'd3,
    CMD_PREPB = 3'd4,
    CMD_PREAB = 3'd5,
    CMD_REF   = 3'd6
  } cmd_t;

  // Request metadata carried through the queue unchanged.
  typedef struct packed {
    logic                      is_wr;
    logic [TAG_WIDTH-1:0]      tag;
    logic [BK_ADDR_WIDTH-1:0]  bk_addr;
    logic [ROW_ADDR_WIDTH-1:0] row_addr;
    logic [COL_ADDR_WIDTH-1:0] col_addr;
  } pkt_meta_t;

endpackage

interface row_hit_arbiter_if #(
  parameter int DEPTH = 8
);
  import row_hit_arbiter_pkg::*;

  logic                              flush;
  pkt_meta_t                         in_pkt;
  logic                              in_pkt_valid;
  logic                              in_pkt_ready;
  pkt_meta_t                         rowarb_pkt;
  logic                              rowarb_pkt_req;
  logic                              bke_pkt_ack;
  cmd_t                              bkarb_cmd;
  logic [BK_ADDR_WIDTH-1:0]          bkarb_cmd_bk;
  logic [ROW_ADDR_WIDTH-1:0]         bkarb_cmd_row;
  logic                              bkarb_cmd_valid;
  logic [$clog2(DEPTH):0]            q_count;

  modport master (
    output flush, in_pkt, in_pkt_valid, bke_pkt_ack,
           bkarb_cmd, bkarb_cmd_bk, bkarb_cmd_row, bkarb_cmd_valid,
    input  in_pkt_ready, rowarb_pkt, rowarb_pkt_req, q_count
  );

  modport slave (
    input  flush, in_pkt, in_pkt_valid, bke_pkt_ack,
           bkarb_cmd, bkarb_cmd_bk, bkarb_cmd_row, bkarb_cmd_valid,
    output in_pkt_ready, rowarb_pkt, rowarb_pkt_req, q_count
  );

endinterface

// File: rtl/row_hit_arbiter.sv
// Row-hit-first request arbiter.
// Requests sit in an age-ordered queue (slot 0 oldest). When the output
// register is free, the oldest request that hits an open row is promoted
// ahead of older misses, but the oldest entry may only be bypassed
// STARVE_MAX times in a row. Flush stops intake and drains strictly in age
// order. The open-row table tracks ACT/PRE broadcasts from the bank arbiter.

module row_hit_arbiter
  import row_hit_arbiter_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  row_hit_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BYP_W = 4;
  localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
  localparam logic [BYP_W-1:0] STARVE_LIM = BYP_W'(STARVE_MAX);

  // Queue storage and occupancy
  pkt_meta_t                 queue     [DEPTH];
  logic [CNT_W-1:0]          count;

  // Output stage and starvation tracking
  pkt_meta_t                 out_pkt;
  logic                      out_req;
  logic [BYP_W-1:0]          bypass_cnt;

  // Open-row table, one entry per bank
  logic [NUM_BANKS-1:0]      row_open;
  logic [ROW_ADDR_WIDTH-1:0] open_row  [NUM_BANKS];

  // Combinational decisions for the coming edge
  logic                      ready;
  logic                      push;
  logic                      load;
  logic                      starving;
  logic                      any_hit;
  logic [DEPTH-1:0]          hit_vec;
  logic [IDX_W-1:0]          hit_idx;
  logic [IDX_W-1:0]          sel_idx;
  logic [CNT_W-1:0]          wr_pos;
  logic [CNT_W-1:0]          count_nxt;
  pkt_meta_t                 queue_nxt [DEPTH];

  // Intake is judged on the pre-edge count, so a push never lands on a
  // full queue even when a removal happens in the same edge.
  assign ready    = (count < DEPTH_CNT) && !bus.flush;
  assign push     = bus.in_pkt_valid && ready;
  assign load     = (!out_req || bus.bke_pkt_ack) && (count != {CNT_W{1'b0}});
  assign starving = (bypass_cnt == STARVE_LIM);

  assign bus.in_pkt_ready   = ready;
  assign bus.rowarb_pkt     = out_pkt;
  assign bus.rowarb_pkt_req = out_req;
  assign bus.q_count        = count;

  // Mark each occupied slot whose bank currently has its row open
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < count) begin
        hit_vec[i] = row_open[queue[i].bk_addr] &&
                     (open_row[queue[i].bk_addr] == queue[i].row_addr);
      end else begin
        hit_vec[i] = 1'b0;
      end
    end
  end

  // Find the oldest (lowest-index) hitting slot
  always_comb begin
    hit_idx = {IDX_W{1'b0}};
    any_hit = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      hit_idx = hit_vec[i] ? IDX_W'(i) : hit_idx;
      any_hit = any_hit | hit_vec[i];
    end
  end

  // Pick the slot to promote: flush and starvation force the oldest entry
  always_comb begin
    if (bus.flush || starving || !any_hit) begin
      sel_idx = {IDX_W{1'b0}};
    end else begin
      sel_idx = hit_idx;
    end
  end

  // Next queue image: compact over the removed slot, then append at the tail
  always_comb begin
    wr_pos = count - {{(CNT_W-1){1'b0}}, load};
    for (int i = 0; i < DEPTH; i++) begin
      if (load && (IDX_W'(i) >= sel_idx) && (i != DEPTH - 1)) begin
        queue_nxt[i] = queue[(i + 1) % DEPTH];
      end else begin
        queue_nxt[i] = queue[i];
      end
      if (push && (CNT_W'(i) == wr_pos)) begin
        queue_nxt[i] = bus.in_pkt;
      end else begin
        queue_nxt[i] = queue_nxt[i];
      end
    end
  end

  // Occupancy after this edge's push and removal
  always_comb begin
    case ({push, load})
      2'b10:   count_nxt = count + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_nxt = count - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_nxt = count;
    endcase
  end

  // Queue contents and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= '0;
      end
      count <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        queue[i] <= queue_nxt[i];
      end
      count <= count_nxt;
    end
  end

  // Output register and bypass counter; the presented packet only changes on a load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pkt    <= '0;
      out_req    <= 1'b0;
      bypass_cnt <= {BYP_W{1'b0}};
    end else if (load) begin
      out_pkt <= queue[sel_idx];
      out_req <= 1'b1;
      if (sel_idx != {IDX_W{1'b0}}) begin
        bypass_cnt <= starving ? bypass_cnt : bypass_cnt + 4'd1;
      end else begin
        bypass_cnt <= {BYP_W{1'b0}};
      end
    end else if (out_req && bus.bke_pkt_ack) begin
      // Taken with nothing behind it: withdraw, leave the stale packet
      out_req <= 1'b0;
    end else begin
      out_req <= out_req;
    end
  end

  // Track open rows from the bank arbiter's broadcast commands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_open <= {NUM_BANKS{1'b0}};
      for (int b = 0; b < NUM_BANKS; b++) begin
        open_row[b] <= {ROW_ADDR_WIDTH{1'b0}};
      end
    end else if (bus.bkarb_cmd_valid) begin
      case (bus.bkarb_cmd)
        CMD_ACT: begin
          row_open[bus.bkarb_cmd_bk] <= 1'b1;
          open_row[bus.bkarb_cmd_bk] <= bus.bkarb_cmd_row;
        end
        CMD_PREPB: row_open[bus.bkarb_cmd_bk] <= 1'b0;
        CMD_PREAB: row_open <= {NUM_BANKS{1'b0}};
        default:   row_open <= row_open;
      endcase
    end else begin
      row_open <= row_open;
    end
  end

endmodule

// File: tb/tb_row_hit_arbiter.sv
// Bench for row_hit_arbiter: a queue-based reference model checks every
// cycle; a vector table and hand sequences cover the ordering corner cases.

module tb_row_hit_arbiter;
  import row_hit_arbiter_pkg::*;

  localparam int DEPTH  = 8;
  localparam int STARVE = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  row_hit_arbiter_if #(.DEPTH(DEPTH)) bus ();

  row_hit_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  pkt_meta_t                 mq[$];
  pkt_meta_t                 m_out;
  bit                        m_req;
  int                        m_byp;
  bit                        m_open [NUM_BANKS];
  logic [ROW_ADDR_WIDTH-1:0] m_row  [NUM_BANKS];

  typedef struct {
    bit        valid;
    pkt_meta_t pkt;
    bit        ack;
    bit        cmd_v;
    cmd_t      cmd;
    int        bk;
    int        row;
    bit        exp_req;
    int        exp_tag;
    int        exp_q;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic pkt_meta_t mkpkt(input int tag, input int bk, input int row);
    pkt_meta_t p;
    p = '0;
    p.tag      = TAG_WIDTH'(tag);
    p.bk_addr  = BK_ADDR_WIDTH'(bk);
    p.row_addr = ROW_ADDR_WIDTH'(row);
    p.col_addr = COL_ADDR_WIDTH'(tag * 7);
    p.is_wr    = tag[0];
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_out = '0;
    m_req = 1'b0;
    m_byp = 0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      m_open[b] = 1'b0;
      m_row[b]  = '0;
    end
  endtask

  // Apply one clock edge's worth of the arbitration rules to the model
  task automatic model_step();
    bit rdy, psh, ld;
    int sel;
    rdy = (mq.size() < DEPTH) && !bus.flush;
    psh = bus.in_pkt_valid && rdy;
    ld  = (!m_req || bus.bke_pkt_ack) && (mq.size() > 0);
    if (ld) begin
      sel = 0;
      if (!bus.flush && m_byp != STARVE) begin
        for (int i = 0; i < mq.size(); i++) begin
          if (m_open[mq[i].bk_addr] && m_row[mq[i].bk_addr] == mq[i].row_addr) begin
            sel = i;
            break;
          end
        end
      end
      m_out = mq[sel];
      mq.delete(sel);
      m_req = 1'b1;
      if (sel == 0) m_byp = 0;
      else m_byp = (m_byp + 1 > STARVE) ? STARVE : m_byp + 1;
    end else if (bus.bke_pkt_ack) begin
      m_req = 1'b0;
    end
    if (psh) mq.push_back(bus.in_pkt);
    if (bus.bkarb_cmd_valid) begin
      case (bus.bkarb_cmd)
        CMD_ACT: begin
          m_open[bus.bkarb_cmd_bk] = 1'b1;
          m_row[bus.bkarb_cmd_bk]  = bus.bkarb_cmd_row;
        end
        CMD_PREPB: m_open[bus.bkarb_cmd_bk] = 1'b0;
        CMD_PREAB: for (int b = 0; b < NUM_BANKS; b++) m_open[b] = 1'b0;
        default: ;
      endcase
    end
  endtask

  // One clock: advance model, take the edge, compare all outputs
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("req", 64'(bus.rowarb_pkt_req), 64'(m_req));
    check("q_count", 64'(bus.q_count), 64'(mq.size()));
    check("ready", 64'(bus.in_pkt_ready), 64'((mq.size() < DEPTH) && !bus.flush));
    check("pkt", 64'(bus.rowarb_pkt), 64'(m_out));
  endtask

  task automatic idle();
    bus.in_pkt_valid    = 1'b0;
    bus.in_pkt          = '0;
    bus.bke_pkt_ack     = 1'b0;
    bus.bkarb_cmd_valid = 1'b0;
    bus.bkarb_cmd       = CMD_NOP;
    bus.bkarb_cmd_bk    = '0;
    bus.bkarb_cmd_row   = '0;
  endtask

  task automatic push(input int tag, input int bk, input int row);
    idle();
    bus.in_pkt_valid = 1'b1;
    bus.in_pkt       = mkpkt(tag, bk, row);
    step();
  endtask

  task automatic cmd(input cmd_t c, input int bk, input int row);
    idle();
    bus.bkarb_cmd_valid = 1'b1;
    bus.bkarb_cmd       = c;
    bus.bkarb_cmd_bk    = BK_ADDR_WIDTH'(bk);
    bus.bkarb_cmd_row   = ROW_ADDR_WIDTH'(row);
    step();
  endtask

  task automatic ack_expect(input string name, input int tag);
    idle();
    bus.bke_pkt_ack = 1'b1;
    step();
    check({name, "_req"}, 64'(bus.rowarb_pkt_req), 64'd1);
    check({name, "_tag"}, 64'(bus.rowarb_pkt.tag), 64'(tag));
  endtask

  task automatic ack_expect_empty(input string name);
    idle();
    bus.bke_pkt_ack = 1'b1;
    step();
    check({name, "_drop"}, 64'(bus.rowarb_pkt_req), 64'd0);
  endtask

  task automatic setv(input int i, input bit v, input pkt_meta_t p, input bit a,
                      input bit cv, input cmd_t c, input int bk, input int row,
                      input bit er, input int et, input int eq);
    tbl[i].valid = v;   tbl[i].pkt = p;       tbl[i].ack = a;
    tbl[i].cmd_v = cv;  tbl[i].cmd = c;       tbl[i].bk = bk;   tbl[i].row = row;
    tbl[i].exp_req = er; tbl[i].exp_tag = et; tbl[i].exp_q = eq;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle();
    bus.flush = 1'b0;
    model_reset();

    // Starvation table: F fills output, X is an old miss, H1..H5 hit bk2 row3
    setv(0,  1'b0, '0, 1'b0, 1'b1, CMD_ACT, 2, 3, 1'b0, 0, 0);
    setv(1,  1'b1, mkpkt(10, 5, 1), 1'b0, 1'b0, CMD_NOP, 0, 0, 1'b0, 0, 1);
    setv(2,  1'b1, mkpkt(11, 2, 9), 1'b0, 1'b0, CMD_NOP, 0, 0, 1'b1, 10, 1);
    for (int k = 0; k < 5; k++)
      setv(3 + k, 1'b1, mkpkt(1 + k, 2, 3), 1'b0, 1'b0, CMD_NOP, 0, 0, 1'b1, 10, 2 + k);
    setv(8,  1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 1, 5);
    setv(9,  1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 2, 4);
    setv(10, 1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 3, 3);
    setv(11, 1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 4, 2);
    setv(12, 1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 11, 1);
    setv(13, 1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b1, 5, 0);
    setv(14, 1'b0, '0, 1'b1, 1'b0, CMD_NOP, 0, 0, 1'b0, 0, 0);

    // Reset state
    rst = 1'b1;
    #1;
    check("rst_req", 64'(bus.rowarb_pkt_req), 64'd0);
    check("rst_q", 64'(bus.q_count), 64'd0);
    check("rst_ready", 64'(bus.in_pkt_ready), 64'd1);
    check("rst_pkt", 64'(bus.rowarb_pkt), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven starvation sequence
    for (int i = 0; i < 15; i++) begin
      idle();
      bus.in_pkt_valid    = tbl[i].valid;
      bus.in_pkt          = tbl[i].pkt;
      bus.bke_pkt_ack     = tbl[i].ack;
      bus.bkarb_cmd_valid = tbl[i].cmd_v;
      bus.bkarb_cmd       = tbl[i].cmd;
      bus.bkarb_cmd_bk    = BK_ADDR_WIDTH'(tbl[i].bk);
      bus.bkarb_cmd_row   = ROW_ADDR_WIDTH'(tbl[i].row);
      step();
      check("tbl_req", 64'(bus.rowarb_pkt_req), 64'(tbl[i].exp_req));
      check("tbl_q", 64'(bus.q_count), 64'(tbl[i].exp_q));
      if (tbl[i].exp_req) check("tbl_tag", 64'(bus.rowarb_pkt.tag), 64'(tbl[i].exp_tag));
    end

    // Hit ordering: A, C (hit), B
    cmd(CMD_ACT, 0, 5);
    push(20, 0, 5);
    check("lat_q", 64'(bus.q_count), 64'd1);
    push(21, 1, 7);
    check("lat_req", 64'(bus.rowarb_pkt_req), 64'd1);
    check("order_a", 64'(bus.rowarb_pkt.tag), 64'd20);
    push(22, 0, 5);
    ack_expect("order_c", 22);
    ack_expect("order_b", 21);
    ack_expect_empty("order_end");

    // Full queue plus output register
    for (int k = 0; k < DEPTH + 1; k++) push(30 + k, 6, k);
    check("full_q", 64'(bus.q_count), 64'(DEPTH));
    check("full_ready", 64'(bus.in_pkt_ready), 64'd0);
    push(50, 6, 0);
    check("full_hold", 64'(bus.q_count), 64'(DEPTH));
    ack_expect("full_ack", 31);
    check("full_ready2", 64'(bus.in_pkt_ready), 64'd1);
    check("full_q2", 64'(bus.q_count), 64'(DEPTH - 1));
    for (int k = 0; k < 20 && bus.rowarb_pkt_req; k++) begin
      idle();
      bus.bke_pkt_ack = 1'b1;
      step();
    end
    check("full_drain", 64'(bus.rowarb_pkt_req), 64'd0);

    // Flush: E3 would hit, but age order wins
    push(40, 3, 1);
    push(41, 4, 2);
    push(42, 0, 5);
    idle();
    bus.flush = 1'b1;
    step();
    check("flush_ready", 64'(bus.in_pkt_ready), 64'd0);
    check("flush_keep", 64'(bus.rowarb_pkt.tag), 64'd40);
    ack_expect("flush_e2", 41);
    ack_expect("flush_e3", 42);
    ack_expect_empty("flush_end");
    bus.flush = 1'b0;

    // PREAB closes bk1: miss M goes first
    cmd(CMD_ACT, 1, 2);
    cmd(CMD_PREAB, 0, 0);
    push(45, 7, 7);
    push(46, 7, 1);
    push(47, 1, 2);
    ack_expect("preab_m", 46);
    ack_expect("preab_h", 47);
    ack_expect_empty("preab_end");

    // Asynchronous reset with queued and presented packets
    for (int k = 0; k < 6; k++) push(50 + k, 3, k);
    check("pre_rst_q", 64'(bus.q_count), 64'd5);
    idle();
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", 64'(bus.rowarb_pkt_req), 64'd0);
    check("arst_q", 64'(bus.q_count), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(60, 2, 2);
    idle();
    step();
    check("post_rst_req", 64'(bus.rowarb_pkt_req), 64'd1);
    check("post_rst_tag", 64'(bus.rowarb_pkt.tag), 64'd60);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle();
      bus.in_pkt_valid = ($urandom_range(0, 9) < 6);
      bus.in_pkt       = mkpkt($urandom_range(0, 63), $urandom_range(0, 3), $urandom_range(0, 3));
      bus.bke_pkt_ack  = $urandom_range(0, 1);
      if ($urandom_range(0, 9) < 3) begin
        r = $urandom_range(0, 9);
        bus.bkarb_cmd_valid = 1'b1;
        bus.bkarb_cmd = (r < 5) ? CMD_ACT : (r < 7) ? CMD_PREPB : (r == 7) ? CMD_PREAB :
                        (r == 8) ? CMD_RD : CMD_NOP;
        bus.bkarb_cmd_bk  = BK_ADDR_WIDTH'($urandom_range(0, 3));
        bus.bkarb_cmd_row = ROW_ADDR_WIDTH'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 49) == 0) bus.flush = ~bus.flush;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
